// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master side is the producer/consumer, the slave side is the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_dir;
  logic             sout_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid, load_data, load_dir, sout_ready,
    input  load_ready, dout, dout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  load_valid, load_data, load_dir, sout_ready,
    output load_ready, dout, dout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding register so
// consecutive words leave back-to-back without a bubble.
module piso_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       SHIFT    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_dir_q, hold_dir_d;
  logic             hold_full_q, hold_full_d;

  logic dout_q, dout_d;
  logic valid_q, valid_d;
  logic fs_q, fs_d;
  logic fe_q, fe_d;
  logic busy_q, busy_d;
  logic load_ready_q, load_ready_d;

  logic accept;
  logic consume;
  logic last;
  logic direct_reload;

  // Next-state logic; every output is precomputed from the next state so the
  // registered outputs match what the registers will hold after the edge.
  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    dir_d         = dir_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_dir_d    = hold_dir_q;
    hold_full_d   = hold_full_q;
    accept        = bus.load_valid && !hold_full_q;
    consume       = (state_q == SHIFT) && bus.sout_ready;
    last          = (cnt_q == CNT_LAST);
    direct_reload = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = bus.load_data;
          dir_d   = bus.load_dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (consume) begin
          if (!last) begin
            sreg_d = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (hold_full_q) begin
            sreg_d      = hold_q;
            dir_d       = hold_dir_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sreg_d        = bus.load_data;
            dir_d         = bus.load_dir;
            cnt_d         = '0;
            direct_reload = 1'b1;
          end else begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        // An accept here can only happen with the hold register empty.
        if (accept && !direct_reload) begin
          hold_d      = bus.load_data;
          hold_dir_d  = bus.load_dir;
          hold_full_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d      = (state_d == SHIFT);
    dout_d       = valid_d && (dir_d ? sreg_d[0] : sreg_d[WIDTH-1]);
    fs_d         = valid_d && (cnt_d == '0);
    fe_d         = valid_d && (cnt_d == CNT_LAST);
    busy_d       = valid_d || hold_full_d;
    load_ready_d = !hold_full_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_dir_q   <= 1'b0;
      hold_full_q  <= 1'b0;
      dout_q       <= 1'b0;
      valid_q      <= 1'b0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_dir_q   <= hold_dir_d;
      hold_full_q  <= hold_full_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.busy        = busy_q;
  assign bus.load_ready  = load_ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scenario bench for piso_serializer: expected bits are queued when a word is
// accepted and popped as the serial side consumes them.
module tb_piso_serializer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic d;
    logic fs;
    logic fe;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         dir;
  } word_t;

  logic clk;
  logic rst_n;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t  exp_q[$];
  word_t src_q[$];
  int    vectors;
  int    miscompares;

  always #5 clk = ~clk;

  // Presents the head word; if it will be accepted at the coming edge, queue its bits.
  task automatic step_producer();
    exp_t e;
    if (src_q.size() != 0) begin
      bus.load_valid = 1'b1;
      bus.load_data  = src_q[0].data;
      bus.load_dir   = src_q[0].dir;
      if (bus.load_ready === 1'b1) begin
        for (int i = 0; i < W; i++) begin
          e.d  = src_q[0].dir ? src_q[0].data[i] : src_q[0].data[W-1-i];
          e.fs = (i == 0);
          e.fe = (i == W - 1);
          exp_q.push_back(e);
        end
        void'(src_q.pop_front());
      end
    end else begin
      bus.load_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.dout, bus.dout_valid, bus.frame_start, bus.frame_end, bus.busy, bus.load_ready} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000001",
               {bus.dout, bus.dout_valid, bus.frame_start, bus.frame_end, bus.busy, bus.load_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.dout_valid, bus.busy, bus.load_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want 001", {bus.dout_valid, bus.busy, bus.load_ready});
    end
  endtask

  task automatic test_single(input logic [W-1:0] word, input logic dir,
                             input logic [W-1:0] want_seq, input string tag);
    exp_t         e;
    logic [W-1:0] seq;
    int           first;
    seq   = '0;
    first = -1;
    bus.sout_ready = 1'b1;
    src_q.push_back(word_t'{data: word, dir: dir});
    for (int c = 0; c < 40 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (bus.dout_valid && bus.sout_ready && exp_q.size() != 0) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL %s_bit: got d/fs/fe=%b want %b", tag,
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
        seq = {seq[W-2:0], bus.dout};
      end
      step_producer();
    end
    vectors++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bits pending want 0", tag, exp_q.size());
      exp_q.delete();
      src_q.delete();
    end
    vectors++;
    if (first !== 1) begin
      miscompares++;
      $display("FAIL %s_latency: got first bit at cycle %0d want 1", tag, first);
    end
    vectors++;
    if (seq !== want_seq) begin
      miscompares++;
      $display("FAIL %s_sequence: got %b want %b", tag, seq, want_seq);
    end
    @(negedge clk);
    vectors++;
    if ({bus.dout_valid, bus.busy, bus.dout, bus.load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL %s_after: got valid/busy/dout/ready=%b want 0001", tag,
               {bus.dout_valid, bus.busy, bus.dout, bus.load_ready});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   first;
    int   last_c;
    bit   prev_fe;
    bit   saw_not_ready;
    first = -1;
    last_c = -1;
    prev_fe = 1'b0;
    saw_not_ready = 1'b0;
    bus.sout_ready = 1'b1;
    src_q.push_back(word_t'{data: 4'b1100, dir: 1'b0});
    src_q.push_back(word_t'{data: 4'b0011, dir: 1'b1});
    src_q.push_back(word_t'{data: 4'b1111, dir: 1'b0});
    for (int c = 0; c < 60 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (prev_fe) begin
        vectors++;
        if (bus.load_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_after_end: got %b want 1", bus.load_ready);
        end
      end
      if (bus.load_ready === 1'b0) saw_not_ready = 1'b1;
      prev_fe = 1'b0;
      if (bus.dout_valid && exp_q.size() != 0) begin
        if (first < 0) first = c;
        last_c = c;
        e = exp_q.pop_front();
        prev_fe = e.fe;
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL b2b_bit: got d/fs/fe=%b want %b",
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
      end
      step_producer();
    end
    @(negedge clk);
    vectors++;
    if ({bus.load_ready, bus.dout_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_end: got ready/valid=%b want 10", {bus.load_ready, bus.dout_valid});
    end
    vectors++;
    if (exp_q.size() != 0 || src_q.size() != 0 || first < 0 || last_c - first != 11) begin
      miscompares++;
      $display("FAIL b2b_gapless: got span %0d pending %0d want span 11 pending 0",
               last_c - first, exp_q.size());
      exp_q.delete();
      src_q.delete();
    end
    vectors++;
    if (!saw_not_ready) begin
      miscompares++;
      $display("FAIL b2b_hold_full: got load_ready never low want low while hold full");
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   n;
    int   stall_left;
    n = 0;
    stall_left = 3;
    src_q.push_back(word_t'{data: 4'b1001, dir: 1'b0});
    for (int c = 0; c < 40 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      bus.sout_ready = !(n == 2 && stall_left > 0);
      if (!bus.sout_ready && exp_q.size() != 0) begin
        stall_left--;
        vectors++;
        if ({bus.dout_valid, bus.dout, bus.frame_start, bus.frame_end} !== {1'b1, exp_q[0]}) begin
          miscompares++;
          $display("FAIL stall_hold: got v/d/fs/fe=%b want %b",
                   {bus.dout_valid, bus.dout, bus.frame_start, bus.frame_end}, {1'b1, exp_q[0]});
        end
      end else if (bus.dout_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL stall_bit%0d: got d/fs/fe=%b want %b", n,
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
      end
      step_producer();
    end
    vectors++;
    if (n != 4 || stall_left != 0) begin
      miscompares++;
      $display("FAIL stall_count: got %0d bits %0d stalls left want 4 and 0", n, stall_left);
      exp_q.delete();
      src_q.delete();
    end
    bus.sout_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_on_end();
    exp_t e;
    bit   started;
    bit   chk_next;
    bit   pushed;
    int   n;
    started = 1'b0;
    chk_next = 1'b0;
    pushed = 1'b0;
    n = 0;
    bus.sout_ready = 1'b1;
    src_q.push_back(word_t'{data: 4'b1010, dir: 1'b0});
    for (int c = 0; c < 40 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (started && exp_q.size() != 0) begin
        vectors++;
        if (bus.dout_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL end_load_gap: got dout_valid %b want 1", bus.dout_valid);
        end
      end
      if (chk_next) begin
        chk_next = 1'b0;
        vectors++;
        if ({bus.dout_valid, bus.frame_start} !== 2'b11) begin
          miscompares++;
          $display("FAIL end_load_start: got valid/fs=%b want 11", {bus.dout_valid, bus.frame_start});
        end
      end
      if (bus.dout_valid && exp_q.size() != 0) begin
        started = 1'b1;
        e = exp_q.pop_front();
        n++;
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL end_load_bit%0d: got d/fs/fe=%b want %b", n,
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
        if (e.fe && !pushed) begin
          pushed = 1'b1;
          chk_next = 1'b1;
          src_q.push_back(word_t'{data: 4'b0111, dir: 1'b1});
        end
      end
      step_producer();
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL end_load_count: got %0d bits want 8", n);
      exp_q.delete();
      src_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    int   n;
    n = 0;
    bus.sout_ready = 1'b1;
    src_q.push_back(word_t'{data: 4'b0110, dir: 1'b0});
    src_q.push_back(word_t'{data: 4'b0101, dir: 1'b0});
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.dout_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL rst_mid_bit%0d: got d/fs/fe=%b want %b", n,
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
      end
      step_producer();
    end
    @(negedge clk);
    vectors++;
    if ({bus.dout_valid, bus.dout, bus.busy, bus.load_ready} !== 4'b1110) begin
      miscompares++;
      $display("FAIL rst_mid_bit3: got v/d/busy/ready=%b want 1110",
               {bus.dout_valid, bus.dout, bus.busy, bus.load_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.dout_valid, bus.dout, bus.busy, bus.load_ready, bus.frame_start, bus.frame_end} !== 6'b000100) begin
      miscompares++;
      $display("FAIL rst_mid_async: got v/d/busy/ready/fs/fe=%b want 000100",
               {bus.dout_valid, bus.dout, bus.busy, bus.load_ready, bus.frame_start, bus.frame_end});
    end
    exp_q.delete();
    src_q.delete();
    bus.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.dout_valid, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: got valid/busy=%b want 00", {bus.dout_valid, bus.busy});
    end
    test_single(4'b1000, 1'b0, 4'b1000, "post_rst");
  endtask

  task automatic test_random();
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 8; i++)
      src_q.push_back(word_t'{data: W'($urandom_range(0, 15)), dir: 1'($urandom_range(0, 1))});
    for (int c = 0; c < 400 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      bus.sout_ready = ($urandom_range(0, 3) != 0);
      if (bus.dout_valid && bus.sout_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        vectors++;
        if ({bus.dout, bus.frame_start, bus.frame_end} !== e) begin
          miscompares++;
          $display("FAIL rand_bit%0d: got d/fs/fe=%b want %b", n,
                   {bus.dout, bus.frame_start, bus.frame_end}, e);
        end
      end
      step_producer();
    end
    vectors++;
    if (n != 8 * W) begin
      miscompares++;
      $display("FAIL rand_count: got %0d bits want %0d", n, 8 * W);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    vectors = 0;
    miscompares = 0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.load_dir = 1'b0;
    bus.sout_ready = 1'b0;
    test_reset();
    test_single(4'b1010, 1'b0, 4'b1010, "msb_first");
    test_single(4'b1010, 1'b1, 4'b0101, "lsb_first");
    test_back_to_back();
    test_stall();
    test_load_on_end();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
